ft_cmd_stream: RTL
==================

// Module: ft_cmd_stream
// PURPOSE
//   Parametrised FT60x 245-sync-FIFO command/stream engine. Reads one command
//   word per FT RX event, decodes opcode, and streams LEN words to host from
//   either an internal counter pattern or an upstream sample source (valid/ready).
//   Sits between the FT601 pins and the acquisition path.
//   Adds TXE backpressure with no word loss, sample-source flow control,
//   LED control and a status output.
// PARAMETERS
//   DATA_W  16        FT data bus width (16 or 32); opcode = data[DATA_W-1 -: 4]
//   BE_W    DATA_W/8  byte-enable width
//   PL_W    12        payload bits per command, data[PL_W-1:0]; LEN_W = 2*PL_W
// PORTS
//   i_ft_clk     in   1       FT clock; sole clock
//   i_rst        in   1       synchronous, active-high reset
//   i_ft_rxf_n   in   1       FT RX data available (low)
//   i_ft_txe_n   in   1       FT TX space available (low)
//   o_ft_oe_n    out  1       FT output enable (low = FT drives bus)
//   o_ft_rd_n    out  1       FT read strobe
//   o_ft_wr_n    out  1       FT write strobe
//   io_ft_data   inout DATA_W FT data bus
//   io_ft_be     inout BE_W   FT byte enables
//   i_smp_data   in   DATA_W  sample source data
//   i_smp_valid  in   1       sample word available
//   o_smp_ready  out  1       sample consumed this cycle (valid&ready)
//   o_led_mode   out  1       1 = LEDs free-run, 0 = static
//   o_led_data   out  8       static LED value
//   o_busy       out  1       state != IDLE
// BEHAVIOUR
//   Reset (any state, incl. mid-stream): oe_n=rd_n=wr_n=1, bus released, state
//     IDLE, len=0, pattern cnt=0, led_mode=0, led_data=0, o_smp_ready=0, busy=0.
//   FSM: IDLE -> RD_OE -> RD_DATA -> EXEC -> {IDLE | TURN -> STREAM -> IDLE}.
//   IDLE: rxf_n=0 -> RD_OE, oe_n<=0. No TX starts without a command.
//   RD_OE: oe_n=0 one cycle (bus turnaround); rxf_n=0 -> RD_DATA, rd_n<=0.
//     rxf_n=1 -> stay, oe_n held low.
//   RD_DATA: at edge with rd_n=0 & rxf_n=0 capture io_ft_data as cmd; rd_n<=1,
//     oe_n<=1 -> EXEC. rxf_n went high -> rd_n<=1, back to RD_OE, nothing latched.
//   EXEC (1 cycle), by opcode:
//     1 LEN_LO: len[PL_W-1:0]=payload.  2 LEN_HI: len[LEN_W-1:PL_W]=payload.
//     3 STREAM: src=payload[0] (0 counter, 1 samples); cnt=0. len==0 -> IDLE,
//       no writes. Else -> TURN.
//     8 LED: led_mode=payload[8], led_data=payload[7:0].
//     other: ignored. Non-stream opcodes -> IDLE.
//   len persists across commands; only LEN_LO/LEN_HI/reset modify it.
//     The stream counts a working copy.
//   TURN: 1 idle cycle, FPGA starts driving bus (oe_n=1), wr_n=1.
//   STREAM: holding register wd/wd_vld. Load wd when !wd_vld or accepted.
//     Counter source always available; sample source needs i_smp_valid.
//     o_smp_ready=1 exactly on the cycle a sample loads.
//   Write handshake: o_ft_wr_n registered = ~wd_vld. A word transfers at a
//     rising edge with wr_n=0 & txe_n=0. txe_n=1 at that edge: word held, no
//     advance, wr_n stays low, data stable. Each transfer decrements the
//     remaining count. Last transfer -> wr_n<=1, bus released next cycle, IDLE.
//     Counter pattern: cnt increments per transfer, wraps at 2^DATA_W.
//   Bus drive: io_ft_data=wd, io_ft_be=all-ones only in TURN/STREAM.
//     Else high-Z. Never driven while oe_n=0.
//   Bounds: len max 2^LEN_W-1. Sample starvation -> wr_n=1, wait indefinitely.
//     RX commands are ignored until STREAM completes.
// TESTING
//   LEN_LO 0x005, STREAM src0, txe_n=0 -> 5 writes: data 0,1,2,3,4; then IDLE.
//   LEN_LO 0x002, LEN_HI 0x001 -> len=4098; STREAM -> 4098 writes, last 0x1001.
//   Stream len 6 with txe_n high 3 cycles after word 2 -> word 2 held, no
//     dup/skip; output 0..5.
//   STREAM src1, samples A0..A3 with valid gaps, len 4 -> 4 o_smp_ready pulses.
//     FT writes A0..A3 in order. wr_n high during gaps.
//   LED 0x8155 -> led_mode=1, led_data=0x55; STREAM with len 0 -> no wr_n pulse.
//   i_rst mid-stream (word 3 of 10) -> next cycle wr_n=1, bus Z, IDLE.
//     New STREAM restarts at 0.

Source files
------------

// File: rtl/ft_cmd_stream.sv
// ft_cmd_stream
//   Command/stream engine for an FT60x 245-style synchronous FIFO interface.
//   Each host command word is read over the FT bus and decoded. Depending on
//   the opcode, the engine either updates the stream length or the LED
//   settings, or it streams LEN words back to the host. The streamed words
//   come from an internal counter or from an upstream valid/ready sample
//   source.
// Ports
//   i_ft_clk, i_rst          sole clock, synchronous active-high reset
//   i_ft_rxf_n, i_ft_txe_n   FT RX data available / TX space available (low)
//   o_ft_oe_n, o_ft_rd_n,
//   o_ft_wr_n                FT output enable, read strobe, write strobe
//   io_ft_data, io_ft_be     FT data bus and byte enables (bidirectional)
//   i_smp_data, i_smp_valid,
//   o_smp_ready              sample source; ready is high on the load cycle
//   o_led_mode, o_led_data   LED free-run flag, static LED value
//   o_busy                   engine not idle
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for an RX command, bus released
// S_RD_OE   | oe_n low, FT turning the bus around toward us
// S_RD_DATA | rd_n low, command word captured on the next valid edge
// S_EXEC    | one-cycle decode of the captured command
// S_TURN    | one idle cycle, FPGA takes over the bus before writing
// S_STREAM  | holding register feeds the FT write handshake
module ft_cmd_stream #(
   parameter int DATA_W = 16,
   parameter int BE_W   = DATA_W / 8,
   parameter int PL_W   = 12
) (
   input  logic              i_ft_clk,
   input  logic              i_rst,
   input  logic              i_ft_rxf_n,
   input  logic              i_ft_txe_n,
   output logic              o_ft_oe_n,
   output logic              o_ft_rd_n,
   output logic              o_ft_wr_n,
   inout  wire  [DATA_W-1:0] io_ft_data,
   inout  wire  [BE_W-1:0]   io_ft_be,
   input  logic [DATA_W-1:0] i_smp_data,
   input  logic              i_smp_valid,
   output logic              o_smp_ready,
   output logic              o_led_mode,
   output logic [7:0]        o_led_data,
   output logic              o_busy
);

   localparam int LEN_W = 2 * PL_W;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_OE, S_RD_DATA, S_EXEC, S_TURN, S_STREAM
   } state_t;

   state_t            state_q, state_d;
   logic              oe_n_q, oe_n_d;
   logic              rd_n_q, rd_n_d;
   logic              wr_n_q, wr_n_d;
   logic [3:0]        op_q, op_d;
   logic [PL_W-1:0]   pl_q, pl_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [DATA_W-1:0] cnt_q, cnt_d;
   logic              src_q, src_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic              wd_vld_q, wd_vld_d;
   logic              led_mode_q, led_mode_d;
   logic [7:0]        led_data_q, led_data_d;
   logic              xfer;
   logic              smp_take;
   logic              drive_en;

   always_comb begin
      state_d    = state_q;
      oe_n_d     = oe_n_q;
      rd_n_d     = rd_n_q;
      wr_n_d     = wr_n_q;
      op_d       = op_q;
      pl_d       = pl_q;
      len_d      = len_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      src_d      = src_q;
      wd_d       = wd_q;
      wd_vld_d   = wd_vld_q;
      led_mode_d = led_mode_q;
      led_data_d = led_data_q;
      smp_take   = 1'b0;
      xfer       = (state_q == S_STREAM) && !wr_n_q && !i_ft_txe_n;

      case (state_q)
         S_IDLE: begin
            if (!i_ft_rxf_n) begin
               oe_n_d  = 1'b0;
               state_d = S_RD_OE;
            end
         end
         S_RD_OE: begin
            if (!i_ft_rxf_n) begin
               rd_n_d  = 1'b0;
               state_d = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            rd_n_d = 1'b1;
            if (!rd_n_q && !i_ft_rxf_n) begin
               op_d    = io_ft_data[DATA_W-1 -: 4];
               pl_d    = io_ft_data[PL_W-1:0];
               oe_n_d  = 1'b1;
               state_d = S_EXEC;
            end else begin
               // FIFO emptied under us: retry the read, bus stays with the FT
               state_d = S_RD_OE;
            end
         end
         S_EXEC: begin
            state_d = S_IDLE;
            case (op_q)
               4'h1: len_d[PL_W-1:0]     = pl_q;
               4'h2: len_d[LEN_W-1:PL_W] = pl_q;
               4'h3: begin
                  src_d    = pl_q[0];
                  cnt_d    = '0;
                  rem_d    = len_q;
                  wd_vld_d = 1'b0;
                  if (len_q != '0) state_d = S_TURN;
               end
               4'h8: begin
                  led_mode_d = pl_q[8];
                  led_data_d = pl_q[7:0];
               end
               default: ;
            endcase
         end
         S_TURN: begin
            state_d = S_STREAM;
         end
         S_STREAM: begin
            if (xfer) begin
               rem_d = rem_q - 1'b1;
               cnt_d = cnt_q + 1'b1;
            end
            if (xfer && rem_q == LEN_W'(1)) begin
               wd_vld_d = 1'b0;
               state_d  = S_IDLE;
            end else if (!wd_vld_q || xfer) begin
               // the counter word for the next slot is cnt+1 when the
               // current word leaves on this same edge
               if (!src_q) begin
                  wd_d     = xfer ? cnt_q + 1'b1 : cnt_q;
                  wd_vld_d = 1'b1;
               end else if (i_smp_valid) begin
                  wd_d     = i_smp_data;
                  wd_vld_d = 1'b1;
                  smp_take = 1'b1;
               end else begin
                  wd_vld_d = 1'b0;
               end
            end
            wr_n_d = ~wd_vld_d;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_ft_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         oe_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         op_q       <= '0;
         pl_q       <= '0;
         len_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         src_q      <= 1'b0;
         wd_q       <= '0;
         wd_vld_q   <= 1'b0;
         led_mode_q <= 1'b0;
         led_data_q <= '0;
      end else begin
         state_q    <= state_d;
         oe_n_q     <= oe_n_d;
         rd_n_q     <= rd_n_d;
         wr_n_q     <= wr_n_d;
         op_q       <= op_d;
         pl_q       <= pl_d;
         len_q      <= len_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         src_q      <= src_d;
         wd_q       <= wd_d;
         wd_vld_q   <= wd_vld_d;
         led_mode_q <= led_mode_d;
         led_data_q <= led_data_d;
      end
   end

   assign drive_en    = (state_q == S_TURN) || (state_q == S_STREAM);
   assign io_ft_data  = drive_en ? wd_q : {DATA_W{1'bz}};
   assign io_ft_be    = drive_en ? {BE_W{1'b1}} : {BE_W{1'bz}};
   assign o_ft_oe_n   = oe_n_q;
   assign o_ft_rd_n   = rd_n_q;
   assign o_ft_wr_n   = wr_n_q;
   assign o_smp_ready = smp_take && !i_rst;
   assign o_led_mode  = led_mode_q;
   assign o_led_data  = led_data_q;
   assign o_busy      = (state_q != S_IDLE);

endmodule
